// File: rtl/fifo_upsize_pkg.sv
// ============================================================================
// Module      : fifo_upsize_pkg
// Description : Default geometry shared by the byte-to-word upsizing FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fifo_upsize_pkg;

    localparam int C_DEFAULT_DATA_WIDTH = 8;
    localparam int C_DEFAULT_ADDR_WIDTH = 3;

endpackage : fifo_upsize_pkg

`default_nettype wire

// File: rtl/fifo_upsize_ctrl.sv
// ============================================================================
// Module      : fifo_upsize_ctrl
// Description : Pointer, byte-count and flag control for the upsizing FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_upsize_ctrl
    import fifo_upsize_pkg::*;
#(
    parameter int ADDR_WIDTH = C_DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic                  rd,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-2:0] r_addr,
    output logic                  wr_en,
    output logic                  full,
    output logic                  empty
);

    localparam logic [ADDR_WIDTH:0]   C_CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   C_CNT_TWO  = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0]   C_CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] C_WPTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-2:0] C_RPTR_ONE = (ADDR_WIDTH-1)'(1);

    logic [ADDR_WIDTH-1:0] w_ptr;
    logic [ADDR_WIDTH-2:0] r_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic [ADDR_WIDTH:0]   cnt_next;
    logic                  rd_acc;
    logic                  wr_acc;

    assign full   = (cnt == C_CNT_FULL);
    assign empty  = (cnt < C_CNT_TWO);

    // A full FIFO still takes a byte when a word leaves in the same cycle.
    assign rd_acc = rd & ~empty;
    assign wr_acc = wr & (~full | rd_acc);

    assign w_addr = w_ptr;
    assign r_addr = r_ptr;
    assign wr_en  = wr_acc;

    always_comb begin
        cnt_next = cnt;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_next = cnt + C_CNT_ONE;
            2'b01:   cnt_next = cnt - C_CNT_TWO;
            2'b11:   cnt_next = cnt - C_CNT_ONE;
            default: cnt_next = cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            cnt   <= '0;
        end else begin
            if (wr_acc) begin
                w_ptr <= w_ptr + C_WPTR_ONE;
            end
            if (rd_acc) begin
                r_ptr <= r_ptr + C_RPTR_ONE;
            end
            cnt <= cnt_next;
        end
    end

endmodule : fifo_upsize_ctrl

`default_nettype wire

// File: rtl/fifo_upsize.sv
// ============================================================================
// Module      : fifo_upsize
// Description : FWFT FIFO packing pairs of written bytes into read words.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fifo_upsize
    import fifo_upsize_pkg::*;
#(
    parameter int DATA_WIDTH = C_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_DEFAULT_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic                    rd,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    full,
    output logic                    empty
);

    localparam int C_DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] storage [C_DEPTH];
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [ADDR_WIDTH-2:0] r_addr;
    logic                  wr_en;

    fifo_upsize_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .rd     (rd),
        .w_addr (w_addr),
        .r_addr (r_addr),
        .wr_en  (wr_en),
        .full   (full),
        .empty  (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (wr_en) begin
            storage[w_addr] <= w_data;
        end
    end

    // Even slot holds the older byte, so it lands in the upper half.
    assign r_data = {storage[{r_addr, 1'b0}], storage[{r_addr, 1'b1}]};

endmodule : fifo_upsize

`default_nettype wire

// File: tb/tb_fifo_upsize.sv
// Bench for fifo_upsize: directed scenarios plus random traffic against a byte-queue model.
`default_nettype none

module tb_fifo_upsize;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [7:0]  w_data;
    logic        rd;
    logic [15:0] r_data;
    logic        full;
    logic        empty;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q[$];

    fifo_upsize #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (3)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .w_data (w_data),
        .rd     (rd),
        .r_data (r_data),
        .full   (full),
        .empty  (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // Compare DUT state to the model, then apply one cycle of stimulus.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        logic racc;
        logic wacc;
        check("empty", {31'b0, empty}, {31'b0, q.size() < 2});
        check("full", {31'b0, full}, {31'b0, q.size() == 8});
        if (q.size() >= 2) begin
            check("r_data", {16'b0, r_data}, {16'b0, q[0], q[1]});
        end
        wr     = w;
        rd     = r;
        w_data = d;
        racc = r && (q.size() >= 2);
        wacc = w && ((q.size() < 8) || racc);
        if (racc) begin
            void'(q.pop_front());
            void'(q.pop_front());
        end
        if (wacc) begin
            q.push_back(d);
        end
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        wr     = 1'($urandom_range(0, 1));
        rd     = 1'($urandom_range(0, 1));
        w_data = 8'($urandom);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        q.delete();
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_full", {31'b0, full}, 32'd0);
        check("rst_r_data", {16'b0, r_data}, 32'h0);
    endtask

    initial begin
        reset  = 1'b1;
        wr     = 1'b0;
        rd     = 1'b0;
        w_data = 8'h00;
        @(posedge clk);
        #1;
        do_reset();

        // Pack order
        cycle(1'b1, 1'b0, 8'hab);
        check("pack_half_empty", {31'b0, empty}, 32'd1);
        cycle(1'b1, 1'b0, 8'hcd);
        check("pack_empty", {31'b0, empty}, 32'd0);
        check("pack_data", {16'b0, r_data}, 32'habcd);
        cycle(1'b0, 1'b1, 8'h00);
        check("pack_pop_empty", {31'b0, empty}, 32'd1);

        // Fill and overflow
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i));
        check("fill_full", {31'b0, full}, 32'd1);
        cycle(1'b1, 1'b0, 8'h09);
        check("ovf_full", {31'b0, full}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check("ovf_read", {16'b0, r_data}, {16'b0, 8'(2*k+1), 8'(2*k+2)});
            cycle(1'b0, 1'b1, 8'h00);
        end
        check("drain_empty", {31'b0, empty}, 32'd1);
        check("drain_full", {31'b0, full}, 32'd0);

        // Simultaneous write and read while full
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 8'(i));
        cycle(1'b1, 1'b1, 8'h09);
        check("wrrd_full", {31'b0, full}, 32'd0);
        check("wrrd_head", {16'b0, r_data}, 32'h0304);
        for (int k = 1; k < 4; k++) begin
            check("wrrd_read", {16'b0, r_data}, {16'b0, 8'(2*k+1), 8'(2*k+2)});
            cycle(1'b0, 1'b1, 8'h00);
        end
        check("wrrd_empty", {31'b0, empty}, 32'd1);
        cycle(1'b1, 1'b0, 8'h0a);
        check("wrap_data", {16'b0, r_data}, 32'h090a);

        // Read with a lone byte stored
        do_reset();
        cycle(1'b1, 1'b0, 8'h11);
        cycle(1'b0, 1'b1, 8'h00);
        check("odd_empty", {31'b0, empty}, 32'd1);
        cycle(1'b1, 1'b0, 8'h22);
        check("odd_data", {16'b0, r_data}, 32'h1122);

        // Reset mid-operation
        do_reset();
        cycle(1'b1, 1'b0, 8'h01);
        cycle(1'b1, 1'b0, 8'h02);
        cycle(1'b1, 1'b0, 8'h03);
        do_reset();
        cycle(1'b1, 1'b0, 8'h04);
        cycle(1'b1, 1'b0, 8'h05);
        check("mid_rst_data", {16'b0, r_data}, 32'h0405);

        // Random traffic, biased in phases toward filling or draining
        for (int n = 0; n < 3000; n++) begin
            int wp;
            int rp;
            wp = ((n / 200) % 2 == 0) ? 75 : 35;
            rp = ((n / 200) % 2 == 0) ? 35 : 75;
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp), 8'($urandom));
            end
        end
        cycle(1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_fifo_upsize

`default_nettype wire
